// File: rtl/bcd_display_scanner_pkg.sv
// Shared constants and helpers for the BCD display scan controller.
package bcd_display_scanner_pkg;

  localparam int         DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bcd_display_scanner_prescaler.sv
// Free-running divider: one-cycle tick every PRESCALE clocks, reusable for refresh timing.
module scan_prescaler
  import bcd_display_scanner_pkg::*;
#(
  parameter int PRESCALE = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int            CW   = cnt_w(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_count <= '0;
    else if (r_count == LAST)  r_count <= '0;
    else                       r_count <= r_count + 1'b1;
  end

  assign tick = (r_count == LAST);

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed N-digit BCD scan controller with tear-free frame handshake.
module bcd_display_scanner
  import bcd_display_scanner_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] load_data,
  input  logic                          load_valid,
  output logic                          load_ready,
  input  logic                          blank_lz,
  output logic [DIGIT_W-1:0]            bcd_out,
  output logic [NUM_DIGITS-1:0]         digit_sel,
  output logic                          frame_done,
  output logic                          bcd_err
);

  localparam int               FW       = DIGIT_W * NUM_DIGITS;
  localparam int               IDX_W    = cnt_w(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [IDX_W-1:0]      r_idx;
  logic [FW-1:0]         r_shadow;
  logic [FW-1:0]         r_pending;
  logic                  r_load_ready;
  logic [DIGIT_W-1:0]    r_bcd_out;
  logic [NUM_DIGITS-1:0] r_digit_sel;
  logic                  r_frame_done;
  logic                  r_bcd_err;

  logic                  w_tick;
  logic [IDX_W-1:0]      w_idx_next;
  logic                  w_boundary;
  logic                  w_consume;
  logic                  w_xfer;
  logic [FW-1:0]         w_frame_eff;
  logic [FW-1:0]         w_clean;
  logic                  w_bad;
  logic [NUM_DIGITS-1:0] w_dark;
  logic [NUM_DIGITS-1:0] w_sel;
  logic [DIGIT_W-1:0]    w_digit;

  scan_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (w_tick)
  );

  assign w_idx_next = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
  assign w_boundary = w_tick & (w_idx_next == '0);
  // A pending frame is swapped in at the boundary so digit 0 already shows it.
  assign w_consume   = w_boundary & ~r_load_ready;
  assign w_xfer      = load_valid & r_load_ready;
  assign w_frame_eff = w_consume ? r_pending : r_shadow;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_clean = '0;
    w_bad   = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (load_data[k*DIGIT_W +: DIGIT_W] > BCD_MAX) w_bad = 1'b1;
      else w_clean[k*DIGIT_W +: DIGIT_W] = load_data[k*DIGIT_W +: DIGIT_W];
    end
  end

  always_comb begin
    logic zero_run;
    w_dark   = '0;
    zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run & (w_frame_eff[k*DIGIT_W +: DIGIT_W] == '0);
      if (k != 0) w_dark[k] = blank_lz & zero_run;
    end
  end

  always_comb begin
    w_sel   = '0;
    w_digit = w_frame_eff[int'(w_idx_next)*DIGIT_W +: DIGIT_W];
    for (int k = 0; k < NUM_DIGITS; k++)
      w_sel[k] = (w_idx_next == IDX_W'(k)) & ~w_dark[k];
  end

  // NOTE: the frame registers are reset too, so a blank display follows reset deterministically.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx        <= LAST_IDX;
      r_shadow     <= '0;
      r_pending    <= '0;
      r_load_ready <= 1'b1;
      r_bcd_out    <= '0;
      r_digit_sel  <= '0;
      r_frame_done <= 1'b0;
      r_bcd_err    <= 1'b0;
    end else begin
      r_frame_done <= w_boundary;
      if (w_consume) begin
        r_shadow     <= r_pending;
        r_load_ready <= 1'b1;
      end
      if (w_xfer) begin
        r_pending    <= w_clean;
        r_bcd_err    <= w_bad;
        r_load_ready <= 1'b0;
      end
      if (w_tick) begin
        r_idx       <= w_idx_next;
        r_bcd_out   <= w_digit;
        r_digit_sel <= w_sel;
      end
    end
  end

  assign load_ready = r_load_ready;
  assign bcd_out    = r_bcd_out;
  assign digit_sel  = r_digit_sel;
  assign frame_done = r_frame_done;
  assign bcd_err    = r_bcd_err;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed self-checking bench for bcd_display_scanner, NUM_DIGITS=4, PRESCALE=4.
module tb_bcd_display_scanner;

  localparam int ND = 4;
  localparam int PS = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4*ND-1:0] load_data = '0;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic          blank_lz = 1'b0;
  logic [3:0]    bcd_out;
  logic [ND-1:0] digit_sel;
  logic          frame_done;
  logic          bcd_err;

  int n_checks = 0;
  int n_errors = 0;

  bcd_display_scanner #(.NUM_DIGITS(ND), .PRESCALE(PS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .blank_lz   (blank_lz),
    .bcd_out    (bcd_out),
    .digit_sel  (digit_sel),
    .frame_done (frame_done),
    .bcd_err    (bcd_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!load_ready && n < 100) begin
      step(1);
      n++;
    end
    check("ready_timeout", 32'(load_ready), 32'd1);
  endtask

  task automatic load_frame(input logic [15:0] data);
    wait_ready();
    load_data  = data;
    load_valid = 1'b1;
    step(1);
    load_valid = 1'b0;
    check("ready_low_after_xfer", 32'(load_ready), 32'd0);
  endtask

  // Waits for the boundary consuming the queued frame, then checks each digit slot.
  task automatic check_frame(input logic [15:0] exp_bcd, input logic [3:0] lit);
    wait_ready();
    check("frame_done_at_swap", 32'(frame_done), 32'd1);
    for (int d = 0; d < ND; d++) begin
      if (d > 0) step(PS);
      check($sformatf("bcd_d%0d", d), 32'(bcd_out), 32'(exp_bcd[d*4 +: 4]));
      check($sformatf("sel_d%0d", d), 32'(digit_sel), lit[d] ? 32'(1 << d) : 32'd0);
    end
  endtask

  initial begin
    // Reset state and free-running scan with an empty frame.
    step(2);
    check("rst_ready", 32'(load_ready), 32'd1);
    check("rst_sel", 32'(digit_sel), 32'd0);
    check("rst_bcd", 32'(bcd_out), 32'd0);
    check("rst_fd", 32'(frame_done), 32'd0);
    check("rst_err", 32'(bcd_err), 32'd0);
    rst_n = 1'b1;
    step(3);
    check("pre_tick_sel", 32'(digit_sel), 32'd0);
    check("pre_tick_fd", 32'(frame_done), 32'd0);
    step(1);
    check("first_sel", 32'(digit_sel), 32'b0001);
    check("first_bcd", 32'(bcd_out), 32'd0);
    check("first_fd", 32'(frame_done), 32'd1);
    step(1);
    check("fd_one_cycle", 32'(frame_done), 32'd0);
    step(3);
    check("sel_d1", 32'(digit_sel), 32'b0010);
    step(4);
    check("sel_d2", 32'(digit_sel), 32'b0100);
    step(4);
    check("sel_d3", 32'(digit_sel), 32'b1000);
    check("bcd_d3_empty", 32'(bcd_out), 32'd0);

    // Load 0x1234 right after the first boundary; it shows from the next one.
    do_reset();
    step(4);
    load_data  = 16'h1234;
    load_valid = 1'b1;
    check("ready_before_load", 32'(load_ready), 32'd1);
    step(1);
    load_valid = 1'b0;
    check("ready_low_c5", 32'(load_ready), 32'd0);
    step(14);
    check("ready_low_c19", 32'(load_ready), 32'd0);
    check("old_frame_d3", 32'(bcd_out), 32'd0);
    step(1);
    check("ready_back_c20", 32'(load_ready), 32'd1);
    check("fd_c20", 32'(frame_done), 32'd1);
    check("bcd_c20", 32'(bcd_out), 32'd4);
    check("sel_c20", 32'(digit_sel), 32'b0001);
    for (int d = 1; d < ND; d++) begin
      step(PS);
      check($sformatf("f1234_bcd_d%0d", d), 32'(bcd_out), 32'(4 - d));
      check($sformatf("f1234_sel_d%0d", d), 32'(digit_sel), 32'(1 << d));
    end

    // Leading-zero blanking.
    blank_lz = 1'b1;
    load_frame(16'h0050);
    check_frame(16'h0050, 4'b0011);
    load_frame(16'h0000);
    check_frame(16'h0000, 4'b0001);
    blank_lz = 1'b0;

    // Non-BCD nibble replaced by 0; data offered while not ready is ignored.
    load_frame(16'h12A4);
    check("err_set", 32'(bcd_err), 32'd1);
    load_data  = 16'h9999;
    load_valid = 1'b1;
    step(1);
    load_valid = 1'b0;
    check("ignored_ready", 32'(load_ready), 32'd0);
    check("err_held", 32'(bcd_err), 32'd1);
    check_frame(16'h1204, 4'b1111);
    load_frame(16'h9999);
    check("err_clear", 32'(bcd_err), 32'd0);
    check_frame(16'h9999, 4'b1111);

    // Back-to-back frames with load_valid held: one transfer per boundary.
    wait_ready();
    load_data  = 16'h5678;
    load_valid = 1'b1;
    step(1);
    load_data = 16'h4321;
    check("bb_ready_low", 32'(load_ready), 32'd0);
    wait_ready();
    check("bb_fd_a", 32'(frame_done), 32'd1);
    check("bb_a_d0", 32'(bcd_out), 32'd8);
    step(1);
    load_valid = 1'b0;
    check("bb_b_taken", 32'(load_ready), 32'd0);
    step(PS - 1);
    check("bb_a_d1", 32'(bcd_out), 32'd7);
    step(PS);
    check("bb_a_d2", 32'(bcd_out), 32'd6);
    step(PS);
    check("bb_a_d3", 32'(bcd_out), 32'd5);
    check_frame(16'h4321, 4'b1111);

    // Asynchronous reset mid-dwell on digit 2.
    load_frame(16'h4321);
    check_frame(16'h4321, 4'b1111);
    step(PS);
    check("pre_rst_sel", 32'(digit_sel), 32'b0001);
    step(2 * PS);
    check("pre_rst_d2", 32'(digit_sel), 32'b0100);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_sel", 32'(digit_sel), 32'd0);
    check("async_bcd", 32'(bcd_out), 32'd0);
    check("async_ready", 32'(load_ready), 32'd1);
    step(2);
    rst_n = 1'b1;
    step(PS - 1);
    check("post_rst_dark", 32'(digit_sel), 32'd0);
    step(1);
    check("post_rst_sel", 32'(digit_sel), 32'b0001);
    check("post_rst_bcd", 32'(bcd_out), 32'd0);
    check("post_rst_fd", 32'(frame_done), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
